// File: rtl/ins_fetch_if.sv
// Fetch-unit bus: ROM address/data, redirect requests and the registered instruction.
// The fetch unit drives the ROM address, so it takes the master modport.
interface ins_fetch_if;
    logic [10:0] rom_addr;
    logic [11:0] rom_data;
    logic        stall;
    logic        jump_en;
    logic [10:0] jump_addr;
    logic        call_en;
    logic [10:0] call_addr;
    logic        ret_en;
    logic [11:0] ir;
    logic [10:0] ir_pc;
    logic        ir_valid;
    logic        stack_err;

    modport master (
        output rom_addr,
        input  rom_data,
        input  stall,
        input  jump_en,
        input  jump_addr,
        input  call_en,
        input  call_addr,
        input  ret_en,
        output ir,
        output ir_pc,
        output ir_valid,
        output stack_err
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output stall,
        output jump_en,
        output jump_addr,
        output call_en,
        output call_addr,
        output ret_en,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        input  stack_err
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch: PC, one-cycle ROM fetch into ir, jump/call/return redirects.
// Define INS_FETCH_CALL_STACK_EN to build the return-address stack.
module ins_fetch #(
    parameter logic [10:0] RESET_VECTOR = 11'd0,
    parameter int unsigned STACK_DEPTH  = 8
) (
    input logic         clk,
    input logic         rst_n,
    ins_fetch_if.master bus
);

    logic [10:0] pc_q, pc_d;
    logic [11:0] ir_q, ir_d;
    logic [10:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;

`ifdef INS_FETCH_CALL_STACK_EN
    localparam int unsigned    SpW    = $clog2(STACK_DEPTH + 1);
    localparam int unsigned    IdxW   = $clog2(STACK_DEPTH);
    localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

    logic [SpW-1:0]  sp_q, sp_d;
    logic [10:0]     stack_q [STACK_DEPTH];
    logic            stack_err_q, stack_err_d;
    logic            push;
    logic [IdxW-1:0] push_idx;
    logic [IdxW-1:0] top_idx;
    logic [10:0]     push_val;

    assign push_idx = sp_q[IdxW-1:0];
    assign top_idx  = IdxW'(sp_q - SpW'(1));
    // Return lands on the instruction after the one that issued the call.
    assign push_val = ir_pc_q + 11'd1;
`else
    logic unused_ret;
    assign unused_ret = bus.ret_en;
`endif

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
`ifdef INS_FETCH_CALL_STACK_EN
        sp_d        = sp_q;
        stack_err_d = 1'b0;
        push        = 1'b0;
        if (bus.ret_en) begin
            ir_valid_d = 1'b0;
            if (sp_q == '0) begin
                pc_d        = RESET_VECTOR;
                stack_err_d = 1'b1;
            end else begin
                pc_d = stack_q[top_idx];
                sp_d = sp_q - SpW'(1);
            end
        end else if (bus.call_en) begin
            ir_valid_d = 1'b0;
            pc_d       = bus.call_addr;
            // A full stack still takes the call; the return address is dropped.
            if (sp_q == SpFull) begin
                stack_err_d = 1'b1;
            end else begin
                push = 1'b1;
                sp_d = sp_q + SpW'(1);
            end
        end else
`else
        if (bus.call_en) begin
            ir_valid_d = 1'b0;
            pc_d       = bus.call_addr;
        end else
`endif
        if (bus.jump_en) begin
            ir_valid_d = 1'b0;
            pc_d       = bus.jump_addr;
        end else if (!bus.stall) begin
            ir_d       = bus.rom_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            ir_q       <= 12'h000;
            ir_pc_q    <= 11'd0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

`ifdef INS_FETCH_CALL_STACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q        <= '0;
            stack_err_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Entries are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stack_q[push_idx] <= push_val;
        end
    end

    assign bus.stack_err = stack_err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.rom_addr = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 11'd0: first fetch address after reset.
REQ-002 Parameter STACK_DEPTH, default 8: number of call-stack entries, range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 rom_addr  output  11  instruction ROM address, equal to the PC register (no combinational path from inputs).
REQ-006 rom_data  input  12  instruction word returned combinationally by the ROM for rom_addr.
REQ-007 stall  input  1  hold fetch; PC and instruction register keep their values.
REQ-008 jump_en  input  1, and jump_addr  input  11: unconditional redirect request and its target.
REQ-009 call_en  input  1, and call_addr  input  11: subroutine call request and its target.
REQ-010 ret_en  input  1  return-from-subroutine request.
REQ-011 ir  output  12  registered instruction word.
REQ-012 ir_pc  output  11  address that ir was fetched from.
REQ-013 ir_valid  output  1  ir holds a valid, unflushed instruction.
REQ-014 stack_err  output  1  one-cycle pulse on call-stack overflow or underflow.

Function
REQ-015 The block SHALL, each non-stalled cycle without redirect, perform ir<=rom_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
REQ-016 The block SHALL wrap PC from 11'd2047 to 11'd0 with no flag.
REQ-017 Fetch latency SHALL be one cycle: rom_addr=A in cycle n gives ir=ROM[A] after edge n.
REQ-018 With stall=1 and no redirect, the block SHALL hold pc, ir, ir_pc and ir_valid unchanged.
REQ-019 Redirect priority SHALL be ret_en > call_en > jump_en; lower-priority requests in the same cycle are ignored.
REQ-020 On any redirect the block SHALL load pc with the target and set ir_valid<=0 (one-bubble flush), regardless of stall.
REQ-021 call_en SHALL push (ir_pc+1) mod 2048 onto the stack and load pc<=call_addr.
REQ-022 ret_en SHALL pop the top entry into pc.
REQ-023 Call with stack full SHALL still redirect to call_addr, SHALL NOT push or modify entries, and SHALL pulse stack_err.
REQ-024 Return with stack empty SHALL load pc<=RESET_VECTOR, leave the stack pointer at 0, and pulse stack_err.
REQ-025 stack_err SHALL be 0 in every cycle not covered by REQ-023/REQ-024.
REQ-026 Stack pointer SHALL range 0..STACK_DEPTH; push and pop never occur in the same cycle.

Reset
REQ-027 While rst_n=0 at a rising edge the block SHALL set pc=RESET_VECTOR, ir=12'h000, ir_pc=0, ir_valid=0, stack pointer=0, stack_err=0.
REQ-028 Reset asserted mid-operation SHALL override stall and all redirects; stack contents become don't-care.
REQ-029 The first valid instruction SHALL appear one edge after rst_n rises: ir=ROM[RESET_VECTOR], ir_pc=RESET_VECTOR.

Configuration
REQ-030 Macro INS_FETCH_CALL_STACK_EN SHALL control the call stack.
REQ-031 With INS_FETCH_CALL_STACK_EN defined, REQ-021..REQ-026 SHALL apply.
REQ-032 Without it, no stack storage SHALL be built: call_en SHALL behave as jump to call_addr, ret_en SHALL be ignored (no redirect, no flush), and stack_err SHALL be tied 0.

Verification
REQ-033 Reset release, ROM[0]=12'hA01, ROM[1]=12'h063, no stall -> ir=12'hA01/ir_pc=0, then ir=12'h063/ir_pc=1, rom_addr increments each cycle.
REQ-034 Stall for 3 cycles at pc=5 -> rom_addr stays 5, ir/ir_pc/ir_valid frozen; pc=6 one cycle after stall drops.
REQ-035 jump_en with jump_addr=11'd54 while ir_pc=9 -> next cycle ir_valid=0, rom_addr=54; following cycle ir_pc=54, ir_valid=1.
REQ-036 call_en to 11'd73 with ir_pc=40, later ret_en -> pc=73 after call; pc=41 after return; stack_err stays 0.
REQ-037 STACK_DEPTH+1 nested calls then STACK_DEPTH+1 returns -> stack_err pulses on last call and on last return; final pc=RESET_VECTOR.
REQ-038 ret_en, call_en, jump_en together with stall=1 -> return taken, ir_valid=0; with macro undefined, call_en taken instead and stack_err=0.
